// File: rtl/trig_capture_ctrl.sv
// rtl/trig_capture_ctrl.sv - pre/post trigger capture sequencer for a circular sample buffer
module trig_capture_ctrl #(
    parameter int ADDR_W       = 10,
    parameter int PRE_DEPTH    = 256,
    parameter int AUTO_TIMEOUT = 100000
) (
    input  logic              ad_clk,
    input  logic              rst_n,
    input  logic              ad_pulse,
    input  logic [7:0]        ad_data,
    input  logic              trig_edge,
    input  logic              trig_mode,
    input  logic              arm,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] rd_start,
    output logic              busy,
    output logic              capture_done,
    output logic              auto_trig
);

    // Samples written after the trigger sample so the whole buffer holds one record
    localparam int POST_LEN = (2 ** ADDR_W) - PRE_DEPTH - 1;
    localparam int TO_W     = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;

    localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_DEPTH - 1);
    localparam logic [ADDR_W-1:0] PRE_OFF   = ADDR_W'(PRE_DEPTH);
    localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'((POST_LEN > 0) ? POST_LEN - 1 : 0);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(AUTO_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRE_FILL,
        WAIT_TRIG,
        POST,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] post_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              pulse_q;

    logic              edge_hit;
    logic              timeout_hit;
    logic              trig_fire;
    logic              arm_ok;
    logic              writing;

    // State register
    always_ff @(posedge ad_clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus per-cycle control strobes for the datapath
    always_comb begin
        state_nxt   = state;
        arm_ok      = 1'b0;
        writing     = 1'b0;
        trig_fire   = 1'b0;
        timeout_hit = 1'b0;
        edge_hit    = trig_edge ? (!ad_pulse && pulse_q) : (ad_pulse && !pulse_q);
        case (state)
            IDLE, DONE: begin
                if (arm) begin
                    arm_ok    = 1'b1;
                    state_nxt = PRE_FILL;
                end
            end
            PRE_FILL: begin
                writing = 1'b1;
                if (wr_ptr == PRE_LAST) begin
                    state_nxt = WAIT_TRIG;
                end
            end
            WAIT_TRIG: begin
                writing     = 1'b1;
                timeout_hit = !trig_mode && (to_cnt == TO_LAST);
                if (edge_hit || timeout_hit) begin
                    trig_fire = 1'b1;
                    // A full pre-trigger window leaves no room for post samples
                    state_nxt = (POST_LEN == 0) ? DONE : POST;
                end
            end
            POST: begin
                writing = 1'b1;
                if (post_cnt == POST_LAST) begin
                    state_nxt = DONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Busy covers every state that writes the buffer
    always_comb begin
        busy = (state == PRE_FILL) || (state == WAIT_TRIG) || (state == POST);
    end

    // Buffer write port, pointers, counters and capture result registers
    always_ff @(posedge ad_clk) begin
        if (!rst_n) begin
            pulse_q      <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            wr_ptr       <= '0;
            post_cnt     <= '0;
            to_cnt       <= '0;
            trig_addr    <= '0;
            rd_start     <= '0;
            capture_done <= 1'b0;
            auto_trig    <= 1'b0;
        end else begin
            pulse_q <= ad_pulse;
            wr_en   <= writing;
            if (writing) begin
                wr_addr <= wr_ptr;
                wr_data <= ad_data;
                wr_ptr  <= wr_ptr + ADDR_W'(1);
            end

            // Timeout counter saturates so a late switch to auto mode fires at once
            if (state == PRE_FILL) begin
                to_cnt <= '0;
            end else if ((state == WAIT_TRIG) && (to_cnt != TO_LAST)) begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            if (trig_fire) begin
                trig_addr <= wr_ptr;
                rd_start  <= wr_ptr - PRE_OFF;
                auto_trig <= !edge_hit;
                post_cnt  <= '0;
            end else if (state == POST) begin
                post_cnt <= post_cnt + ADDR_W'(1);
            end

            // DONE is entered with the last write in flight, so done trails it by one
            if (state == DONE) begin
                capture_done <= 1'b1;
            end

            if (arm_ok) begin
                wr_ptr       <= '0;
                capture_done <= 1'b0;
                auto_trig    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_trig_capture_ctrl.sv
// tb/tb_trig_capture_ctrl.sv - directed self-checking bench for trig_capture_ctrl
module tb_trig_capture_ctrl;

    logic       ad_clk;
    logic       rst_n;
    logic       ad_pulse;
    logic [7:0] ad_data;
    logic       trig_edge;
    logic       trig_mode;
    logic       arm;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] trig_addr;
    logic [3:0] rd_start;
    logic       busy;
    logic       capture_done;
    logic       auto_trig;

    int n_tests = 0;
    int n_fail  = 0;

    logic       lg_en   [128];
    logic       lg_busy [128];
    logic       lg_cd   [128];
    logic       lg_auto [128];
    logic [3:0] lg_addr [128];
    logic [3:0] lg_trig [128];
    logic [3:0] lg_rd   [128];
    logic [7:0] lg_data [128];

    trig_capture_ctrl #(
        .ADDR_W      (4),
        .PRE_DEPTH   (4),
        .AUTO_TIMEOUT(20)
    ) dut (
        .ad_clk      (ad_clk),
        .rst_n       (rst_n),
        .ad_pulse    (ad_pulse),
        .ad_data     (ad_data),
        .trig_edge   (trig_edge),
        .trig_mode   (trig_mode),
        .arm         (arm),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .trig_addr   (trig_addr),
        .rd_start    (rd_start),
        .busy        (busy),
        .capture_done(capture_done),
        .auto_trig   (auto_trig)
    );

    initial ad_clk = 1'b0;
    always #5 ad_clk = ~ad_clk;

    task automatic step();
        @(posedge ad_clk);
        #1;
    endtask

    // Cycle c of a capture starts here; outputs of cycle c are logged, then its inputs driven
    task automatic run_capture(input logic [127:0] pat, input logic [127:0] arm_pat,
                               input logic edge_sel, input logic mode, input int ncyc,
                               input logic [7:0] seed);
        for (int c = 0; c < ncyc; c++) begin
            lg_en[c]   = wr_en;
            lg_busy[c] = busy;
            lg_cd[c]   = capture_done;
            lg_auto[c] = auto_trig;
            lg_addr[c] = wr_addr;
            lg_trig[c] = trig_addr;
            lg_rd[c]   = rd_start;
            lg_data[c] = wr_data;
            arm        = arm_pat[c];
            ad_pulse   = pat[c];
            ad_data    = 8'(c * 7) + seed;
            trig_edge  = edge_sel;
            trig_mode  = mode;
            step();
        end
        arm = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; arm = 1'b0; ad_pulse = 1'b1; ad_data = 8'hA5;
        trig_edge = 1'b0; trig_mode = 1'b0;
        step(); step();
        n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got %b exp 0", wr_en); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_tests++; if (capture_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", capture_done); end
        n_tests++; if (auto_trig !== 1'b0) begin n_fail++; $display("FAIL reset_auto got %b exp 0", auto_trig); end
        n_tests++; if (trig_addr !== 4'd0) begin n_fail++; $display("FAIL reset_trig_addr got %0d exp 0", trig_addr); end
        n_tests++; if (rd_start !== 4'd0) begin n_fail++; $display("FAIL reset_rd_start got %0d exp 0", rd_start); end
        n_tests++; if (wr_addr !== 4'd0) begin n_fail++; $display("FAIL reset_wr_addr got %0d exp 0", wr_addr); end
        n_tests++; if (wr_data !== 8'd0) begin n_fail++; $display("FAIL reset_wr_data got %0h exp 0", wr_data); end
        rst_n = 1'b1; ad_pulse = 1'b0;
        step();
    endtask

    task automatic test_rising();
        logic [127:0] pat;
        logic [127:0] ap;
        pat = '0; ap = '0; ap[0] = 1'b1;
        pat[2] = 1'b1; pat[3] = 1'b1;
        pat[10] = 1'b1; pat[11] = 1'b1; pat[12] = 1'b1;
        run_capture(pat, ap, 1'b0, 1'b0, 26, 8'h11);
        for (int c = 0; c < 26; c++) begin
            n_tests++; if (lg_en[c] !== (c >= 2 && c <= 22)) begin n_fail++; $display("FAIL rise_wr_en c=%0d got %b", c, lg_en[c]); end
            n_tests++; if (lg_busy[c] !== (c >= 1 && c <= 21)) begin n_fail++; $display("FAIL rise_busy c=%0d got %b", c, lg_busy[c]); end
            n_tests++; if (lg_cd[c] !== (c >= 23)) begin n_fail++; $display("FAIL rise_done c=%0d got %b", c, lg_cd[c]); end
        end
        for (int c = 1; c <= 21; c++) begin
            n_tests++; if (lg_addr[c+1] !== 4'(c - 1)) begin n_fail++; $display("FAIL rise_wr_addr c=%0d got %0d exp %0d", c + 1, lg_addr[c+1], 4'(c - 1)); end
            n_tests++; if (lg_data[c+1] !== 8'(c * 7) + 8'h11) begin n_fail++; $display("FAIL rise_wr_data c=%0d got %0h exp %0h", c + 1, lg_data[c+1], 8'(c * 7) + 8'h11); end
        end
        n_tests++; if (lg_trig[23] !== 4'd9) begin n_fail++; $display("FAIL rise_trig_addr got %0d exp 9", lg_trig[23]); end
        n_tests++; if (lg_rd[23] !== 4'd5) begin n_fail++; $display("FAIL rise_rd_start got %0d exp 5", lg_rd[23]); end
        n_tests++; if (lg_auto[23] !== 1'b0) begin n_fail++; $display("FAIL rise_auto got %b exp 0", lg_auto[23]); end
    endtask

    task automatic test_falling();
        logic [127:0] pat;
        logic [127:0] ap;
        pat = '0; ap = '0; ap[0] = 1'b1;
        for (int c = 8; c <= 11; c++) pat[c] = 1'b1;
        run_capture(pat, ap, 1'b1, 1'b1, 28, 8'h40);
        n_tests++; if (lg_cd[0] !== 1'b1) begin n_fail++; $display("FAIL fall_done_before_arm got %b exp 1", lg_cd[0]); end
        n_tests++; if (lg_cd[1] !== 1'b0) begin n_fail++; $display("FAIL fall_done_cleared got %b exp 0", lg_cd[1]); end
        n_tests++; if (lg_addr[2] !== 4'd0) begin n_fail++; $display("FAIL fall_restart_addr got %0d exp 0", lg_addr[2]); end
        n_tests++; if (lg_busy[23] !== 1'b1) begin n_fail++; $display("FAIL fall_busy23 got %b exp 1", lg_busy[23]); end
        n_tests++; if (lg_busy[24] !== 1'b0) begin n_fail++; $display("FAIL fall_busy24 got %b exp 0", lg_busy[24]); end
        n_tests++; if (lg_en[24] !== 1'b1) begin n_fail++; $display("FAIL fall_wr_en24 got %b exp 1", lg_en[24]); end
        n_tests++; if (lg_en[25] !== 1'b0) begin n_fail++; $display("FAIL fall_wr_en25 got %b exp 0", lg_en[25]); end
        n_tests++; if (lg_cd[24] !== 1'b0) begin n_fail++; $display("FAIL fall_done24 got %b exp 0", lg_cd[24]); end
        n_tests++; if (lg_cd[25] !== 1'b1) begin n_fail++; $display("FAIL fall_done25 got %b exp 1", lg_cd[25]); end
        n_tests++; if (lg_trig[25] !== 4'd11) begin n_fail++; $display("FAIL fall_trig_addr got %0d exp 11", lg_trig[25]); end
        n_tests++; if (lg_rd[25] !== 4'd7) begin n_fail++; $display("FAIL fall_rd_start got %0d exp 7", lg_rd[25]); end
        n_tests++; if (lg_auto[25] !== 1'b0) begin n_fail++; $display("FAIL fall_auto got %b exp 0", lg_auto[25]); end
    endtask

    task automatic test_auto_timeout();
        logic [127:0] pat;
        logic [127:0] ap;
        pat = '0; ap = '0; ap[0] = 1'b1;
        run_capture(pat, ap, 1'b0, 1'b0, 40, 8'h03);
        n_tests++; if (lg_busy[35] !== 1'b1) begin n_fail++; $display("FAIL auto_busy35 got %b exp 1", lg_busy[35]); end
        n_tests++; if (lg_busy[36] !== 1'b0) begin n_fail++; $display("FAIL auto_busy36 got %b exp 0", lg_busy[36]); end
        n_tests++; if (lg_en[36] !== 1'b1) begin n_fail++; $display("FAIL auto_wr_en36 got %b exp 1", lg_en[36]); end
        n_tests++; if (lg_en[37] !== 1'b0) begin n_fail++; $display("FAIL auto_wr_en37 got %b exp 0", lg_en[37]); end
        n_tests++; if (lg_cd[36] !== 1'b0) begin n_fail++; $display("FAIL auto_done36 got %b exp 0", lg_cd[36]); end
        n_tests++; if (lg_cd[37] !== 1'b1) begin n_fail++; $display("FAIL auto_done37 got %b exp 1", lg_cd[37]); end
        n_tests++; if (lg_trig[38] !== 4'd7) begin n_fail++; $display("FAIL auto_trig_addr got %0d exp 7", lg_trig[38]); end
        n_tests++; if (lg_rd[38] !== 4'd3) begin n_fail++; $display("FAIL auto_rd_start got %0d exp 3", lg_rd[38]); end
        n_tests++; if (lg_auto[38] !== 1'b1) begin n_fail++; $display("FAIL auto_flag got %b exp 1", lg_auto[38]); end
    endtask

    task automatic test_coincide_rearm();
        logic [127:0] pat;
        logic [127:0] ap;
        pat = '0; ap = '0;
        ap[0] = 1'b1; ap[3] = 1'b1; ap[15] = 1'b1;
        for (int c = 24; c <= 27; c++) pat[c] = 1'b1;
        run_capture(pat, ap, 1'b0, 1'b0, 40, 8'h77);
        n_tests++; if (lg_auto[0] !== 1'b1) begin n_fail++; $display("FAIL coin_auto_before got %b exp 1", lg_auto[0]); end
        n_tests++; if (lg_auto[1] !== 1'b0) begin n_fail++; $display("FAIL coin_auto_cleared got %b exp 0", lg_auto[1]); end
        for (int c = 1; c <= 35; c++) begin
            n_tests++; if (lg_addr[c+1] !== 4'(c - 1)) begin n_fail++; $display("FAIL coin_wr_addr c=%0d got %0d exp %0d", c + 1, lg_addr[c+1], 4'(c - 1)); end
        end
        n_tests++; if (lg_cd[37] !== 1'b1) begin n_fail++; $display("FAIL coin_done got %b exp 1", lg_cd[37]); end
        n_tests++; if (lg_trig[38] !== 4'd7) begin n_fail++; $display("FAIL coin_trig_addr got %0d exp 7", lg_trig[38]); end
        n_tests++; if (lg_rd[38] !== 4'd3) begin n_fail++; $display("FAIL coin_rd_start got %0d exp 3", lg_rd[38]); end
        n_tests++; if (lg_auto[38] !== 1'b0) begin n_fail++; $display("FAIL coin_auto got %b exp 0", lg_auto[38]); end
    endtask

    task automatic test_normal();
        logic [127:0] pat;
        logic [127:0] ap;
        pat = '0; ap = '0; ap[0] = 1'b1;
        run_capture(pat, ap, 1'b0, 1'b1, 110, 8'h20);
        for (int c = 1; c < 110; c++) begin
            n_tests++; if (lg_busy[c] !== 1'b1) begin n_fail++; $display("FAIL norm_busy c=%0d got %b exp 1", c, lg_busy[c]); end
            n_tests++; if (lg_cd[c] !== 1'b0) begin n_fail++; $display("FAIL norm_done c=%0d got %b exp 0", c, lg_cd[c]); end
            if (c >= 2) begin
                n_tests++; if (lg_en[c] !== 1'b1) begin n_fail++; $display("FAIL norm_wr_en c=%0d got %b exp 1", c, lg_en[c]); end
                n_tests++; if (lg_addr[c] !== 4'(c - 2)) begin n_fail++; $display("FAIL norm_wr_addr c=%0d got %0d exp %0d", c, lg_addr[c], 4'(c - 2)); end
            end
        end
    endtask

    task automatic test_reset_mid_post();
        logic [127:0] pat;
        logic [127:0] ap;
        rst_n = 1'b0; step(); rst_n = 1'b1; step();
        pat = '0; ap = '0; ap[0] = 1'b1;
        pat[10] = 1'b1; pat[11] = 1'b1;
        run_capture(pat, ap, 1'b0, 1'b1, 15, 8'h55);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_pre got %b exp 1", busy); end
        n_tests++; if (trig_addr !== 4'd9) begin n_fail++; $display("FAIL mid_trig_pre got %0d exp 9", trig_addr); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL mid_wr_en got %b exp 0", wr_en); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b exp 0", busy); end
        n_tests++; if (capture_done !== 1'b0) begin n_fail++; $display("FAIL mid_done got %b exp 0", capture_done); end
        n_tests++; if (trig_addr !== 4'd0) begin n_fail++; $display("FAIL mid_trig_addr got %0d exp 0", trig_addr); end
        n_tests++; if (rd_start !== 4'd0) begin n_fail++; $display("FAIL mid_rd_start got %0d exp 0", rd_start); end
        step();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_idle_busy got %b exp 0", busy); end
        n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL mid_idle_wr_en got %b exp 0", wr_en); end
        arm = 1'b1; step(); arm = 1'b0;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_rearm_busy got %b exp 1", busy); end
        step();
        n_tests++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL mid_rearm_wr_en got %b exp 1", wr_en); end
        n_tests++; if (wr_addr !== 4'd0) begin n_fail++; $display("FAIL mid_rearm_addr got %0d exp 0", wr_addr); end
    endtask

    initial begin
        test_reset();
        test_rising();
        test_falling();
        test_auto_timeout();
        test_coincide_rearm();
        test_normal();
        test_reset_mid_post();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/trig_capture_ctrl.md
TRIG_CAPTURE_CTRL -- requirements
Module: trig_capture_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, capture buffer address width (buffer depth 2^ADDR_W).
REQ-002 SHALL have parameter PRE_DEPTH, default 256, pre-trigger sample count; legal range 1..2^ADDR_W-1.
REQ-003 SHALL have parameter AUTO_TIMEOUT, default 100000, cycles in WAIT_TRIG before an auto-mode forced trigger; legal range >=1.
REQ-004 SHALL have port ad_clk  input  1  ADC sample clock; the single clock of the block.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port ad_pulse  input  1  hysteresis-qualified comparator pulse from the pulse generator stage.
REQ-007 SHALL have port ad_data  input  8  ADC sample, same cycle alignment as ad_pulse.
REQ-008 SHALL have port trig_edge  input  1  0 = rising edge of ad_pulse, 1 = falling edge.
REQ-009 SHALL have port trig_mode  input  1  0 = auto, 1 = normal.
REQ-010 SHALL have port arm  input  1  single-cycle capture start request.
REQ-011 SHALL have ports wr_en (output, 1), wr_addr (output, ADDR_W) and wr_data (output, 8): buffer write strobe, address and data.
REQ-012 SHALL have ports trig_addr (output, ADDR_W) and rd_start (output, ADDR_W): trigger sample address and oldest-sample address for readout.
REQ-013 SHALL have ports busy (output, 1), capture_done (output, 1) and auto_trig (output, 1): capture in progress, capture complete (level), and last trigger was forced.

Function
REQ-014 SHALL implement states IDLE, PRE_FILL, WAIT_TRIG, POST, DONE.
REQ-015 SHALL, in IDLE or DONE with arm=1, enter PRE_FILL; clear capture_done and auto_trig; reset the write pointer to 0. SHALL ignore arm in all other states.
REQ-016 SHALL, in PRE_FILL, WAIT_TRIG and POST, write the ad_data of every cycle at the write pointer, then increment the pointer modulo 2^ADDR_W.
REQ-017 SHALL register wr_en, wr_addr and wr_data: each write appears one cycle after its ad_data is sampled.
REQ-018 SHALL stay in PRE_FILL for exactly PRE_DEPTH cycles (addresses 0..PRE_DEPTH-1), then enter WAIT_TRIG; SHALL ignore edges during PRE_FILL.
REQ-019 SHALL keep a registered copy of ad_pulse, updated every cycle in every state, reset 0. An edge in cycle t SHALL be ad_pulse(t)=1, prev=0 (rising) or ad_pulse(t)=0, prev=1 (falling), as selected by trig_edge.
REQ-020 SHALL, in WAIT_TRIG, overwrite circularly; on a selected edge in cycle t, latch trig_addr = address written in cycle t and enter POST.
REQ-021 SHALL count cycles in WAIT_TRIG from 0. In auto mode, if count reaches AUTO_TIMEOUT-1 with no edge, SHALL force a trigger that cycle (same latching as an edge) and set auto_trig=1. In normal mode SHALL wait indefinitely.
REQ-022 SHALL, when a real edge and the timeout coincide, treat it as a real trigger: auto_trig=0.
REQ-023 SHALL write exactly 2^ADDR_W-PRE_DEPTH-1 samples in POST, then enter DONE.
REQ-024 SHALL set rd_start = (trig_addr - PRE_DEPTH) mod 2^ADDR_W, valid whenever capture_done=1.
REQ-025 SHALL set busy=1 in PRE_FILL, WAIT_TRIG and POST.
REQ-026 SHALL assert capture_done on the cycle after the last wr_en=1 cycle; it SHALL hold until the next accepted arm or reset.
REQ-027 SHALL sample trig_edge and trig_mode every cycle; a change takes effect in the same cycle.

Reset
REQ-028 SHALL, with rst_n=0 at a clock edge, enter IDLE and drive all outputs, the write pointer, counters and the ad_pulse copy to 0, from any state including mid-capture; the capture is discarded.

Verification (ADDR_W=4, PRE_DEPTH=4, AUTO_TIMEOUT=20, arm high in cycle 0)
REQ-029 SHALL verify rising trigger: writes in cycles 1..4 go to addresses 0..3; a rising edge in cycle 2 is ignored; a rising edge in cycle 10 gives trig_addr=9 and rd_start=5. POST writes addresses 10..15 and 0..4 in cycles 11..21, with wr_en high in cycles 2..22. capture_done=1 from cycle 23 and auto_trig=0.
REQ-030 SHALL verify falling mode: trig_edge=1 and ad_pulse falls in cycle 12 -> trig_addr=11, rd_start=7; a rising edge in cycle 8 does not trigger.
REQ-031 SHALL verify auto timeout: trig_mode=0 with no edges -> forced trigger in cycle 24, trig_addr=7, rd_start=3, auto_trig=1.
REQ-032 SHALL verify normal mode: trig_mode=1 with no edges for 100 cycles -> busy stays 1, wr_en stays continuous, wr_addr wraps 15->0, capture_done stays 0.
REQ-033 SHALL verify coincidence and re-arm rules: an edge in cycle 24 with auto mode -> auto_trig=0. arm pulses in cycles 3 and 15 are ignored. An arm in DONE restarts at address 0 and clears capture_done in the next cycle.
REQ-034 SHALL verify reset mid-POST: rst_n=0 for one cycle -> next cycle wr_en=0, busy=0, capture_done=0, trig_addr=0, and state IDLE.
